// File: rtl/otter_clk_pkg.sv
// Shared types and constants for the OTTER clock-enable step controller.
package otter_clk_pkg;

    typedef enum logic [1:0] {
        CLK_HALT = 2'd0,
        CLK_RUN  = 2'd1,
        CLK_STEP = 2'd2
    } clk_state_t;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/otter_btn_debounce.sv
// Button synchroniser and debouncer; PRESS pulses for one cycle on each
// accepted rising edge of the debounced level.
module otter_btn_debounce
    import otter_clk_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN,
    output logic PRESS
);

    localparam int unsigned       CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   btn_s;

    assign btn_s = sync_q[SYNC_STAGES-1];

    // Count consecutive mismatch cycles; any agreement restarts the count.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], BTN};
        cnt_d   = '0;
        level_d = level_q;
        if (btn_s != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = btn_s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign PRESS = press_q;

endmodule

// File: rtl/otter_clk_step_ctrl.sv
// OTTER pipeline clock-enable generator: free-run at a divided rate, halt, and
// debounced single-step. Optional CE_COUNT under `OTTER_CLK_CE_COUNT_EN`.
module otter_clk_step_ctrl
    import otter_clk_pkg::*;
#(
    parameter int unsigned DIV_MAX         = 200000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        SW_RUN,
    input  logic        BTN_STEP,
    input  logic        HALT_REQ,
    output logic        CPU_CE,
    output logic        HALTED
`ifdef OTTER_CLK_CE_COUNT_EN
    ,
    output logic [31:0] CE_COUNT
`endif
);

    localparam int unsigned      DIV_W    = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX - 1);

    logic [SYNC_STAGES-1:0] run_sync_q, run_sync_d;
    logic [DIV_W-1:0]       div_q, div_d;
    clk_state_t             state_q, state_d;
    logic                   ce_q, ce_d;
    logic                   run_s;
    logic                   tick;
    logic                   step_req;

    otter_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_btn (
        .CLK  (CLK),
        .RST_N(RST_N),
        .BTN  (BTN_STEP),
        .PRESS(step_req)
    );

    assign run_s = run_sync_q[SYNC_STAGES-1];
    assign tick  = (div_q == DIV_LAST);

    // Divider free-runs regardless of FSM state.
    always_comb begin
        run_sync_d = {run_sync_q[SYNC_STAGES-2:0], SW_RUN};
        div_d      = tick ? '0 : div_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLK_HALT: begin
                if (run_s && !HALT_REQ) begin
                    state_d = CLK_RUN;
                end else if (step_req) begin
                    state_d = CLK_STEP;
                end
            end
            CLK_RUN:  if (HALT_REQ || !run_s) state_d = CLK_HALT;
            CLK_STEP: if (tick) state_d = CLK_HALT;
            default:  state_d = CLK_HALT;
        endcase
    end

    // Halt in RUN wins over a coincident tick.
    always_comb begin
        ce_d = 1'b0;
        case (state_q)
            CLK_RUN:  ce_d = tick && !HALT_REQ && run_s;
            CLK_STEP: ce_d = tick;
            default:  ce_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            run_sync_q <= '0;
            div_q      <= '0;
            state_q    <= CLK_HALT;
            ce_q       <= 1'b0;
        end else begin
            run_sync_q <= run_sync_d;
            div_q      <= div_d;
            state_q    <= state_d;
            ce_q       <= ce_d;
        end
    end

    assign CPU_CE = ce_q;
    assign HALTED = (state_q == CLK_HALT);

`ifdef OTTER_CLK_CE_COUNT_EN
    logic [31:0] ce_count_q, ce_count_d;

    always_comb begin
        ce_count_d = ce_q ? ce_count_q + 32'd1 : ce_count_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ce_count_q <= '0;
        end else begin
            ce_count_q <= ce_count_d;
        end
    end

    assign CE_COUNT = ce_count_q;
`endif

endmodule

// File: tb/tb_otter_clk_step_ctrl.sv
// Self-checking bench for otter_clk_step_ctrl with DIV_MAX=4, DEBOUNCE_CYCLES=3.
module tb_otter_clk_step_ctrl;

    logic        clk;
    logic        rst_n;
    logic        sw_run;
    logic        btn;
    logic        halt_req;
    logic        cpu_ce;
    logic        halted;
`ifdef OTTER_CLK_CE_COUNT_EN
    logic [31:0] ce_count;
`endif

    typedef struct packed {
        logic ce;
        logic halted;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        ex;
    int          checks = 0;
    int          errors = 0;
    int unsigned e;   // clock edges since reset release; divider count is e % 4

    otter_clk_step_ctrl #(
        .DIV_MAX        (4),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .SW_RUN  (sw_run),
        .BTN_STEP(btn),
        .HALT_REQ(halt_req),
        .CPU_CE  (cpu_ce),
        .HALTED  (halted)
`ifdef OTTER_CLK_CE_COUNT_EN
        ,
        .CE_COUNT(ce_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) e <= 0;
        else        e <= e + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0; sw_run = 1'b0; btn = 1'b0; halt_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (cpu_ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b want 0", cpu_ce); end
            checks++;
            if (halted !== 1'b1) begin errors++; $display("FAIL reset_halted: got %b want 1", halted); end
`ifdef OTTER_CLK_CE_COUNT_EN
            checks++;
            if (ce_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", ce_count); end
`endif
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            exp_q.push_back('{ce: 1'b0, halted: 1'b1});
            @(negedge clk);
            ex = exp_q.pop_front();
            checks++;
            if (cpu_ce !== ex.ce) begin errors++; $display("FAIL idle_ce k=%0d: got %b want %b", k, cpu_ce, ex.ce); end
            checks++;
            if (halted !== ex.halted) begin errors++; $display("FAIL idle_halted k=%0d: got %b want %b", k, halted, ex.halted); end
        end
    endtask

    task automatic test_run();
        @(posedge clk); #1;
        sw_run = 1'b1;
        for (int k = 1; k <= 44; k++) begin
            @(posedge clk); #1;
            exp_q.push_back('{ce: (k >= 4) && (e % 4 == 0), halted: (k < 3)});
            @(negedge clk);
            ex = exp_q.pop_front();
            checks++;
            if (cpu_ce !== ex.ce) begin errors++; $display("FAIL run_ce k=%0d e=%0d: got %b want %b", k, e, cpu_ce, ex.ce); end
            checks++;
            if (halted !== ex.halted) begin errors++; $display("FAIL run_halted k=%0d: got %b want %b", k, halted, ex.halted); end
        end
    endtask

    task automatic test_halt_req();
        @(posedge clk); #1;
        for (int k = 0; k < 4 && (e % 4 != 3); k++) begin
            @(posedge clk); #1;
        end
        halt_req = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            halt_req = 1'b0;
            if (k == 1) exp_q.push_back('{ce: 1'b0, halted: 1'b1});
            else        exp_q.push_back('{ce: (e % 4 == 0), halted: 1'b0});
            @(negedge clk);
            ex = exp_q.pop_front();
            checks++;
            if (cpu_ce !== ex.ce) begin errors++; $display("FAIL halt_req_ce k=%0d: got %b want %b", k, cpu_ce, ex.ce); end
            checks++;
            if (halted !== ex.halted) begin errors++; $display("FAIL halt_req_halted k=%0d: got %b want %b", k, halted, ex.halted); end
        end
    endtask

    task automatic test_sw_halt();
        @(posedge clk); #1;
        sw_run = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            exp_q.push_back('{ce: (k < 3) && (e % 4 == 0), halted: (k >= 3)});
            @(negedge clk);
            ex = exp_q.pop_front();
            checks++;
            if (cpu_ce !== ex.ce) begin errors++; $display("FAIL sw_halt_ce k=%0d: got %b want %b", k, cpu_ce, ex.ce); end
            checks++;
            if (halted !== ex.halted) begin errors++; $display("FAIL sw_halt_halted k=%0d: got %b want %b", k, halted, ex.halted); end
        end
    endtask

    task automatic test_bounce();
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk); #1;
            btn = (k <= 10) ? ~btn : 1'b0;
            exp_q.push_back('{ce: 1'b0, halted: 1'b1});
            @(negedge clk);
            ex = exp_q.pop_front();
            checks++;
            if (cpu_ce !== ex.ce) begin errors++; $display("FAIL bounce_ce k=%0d: got %b want %b", k, cpu_ce, ex.ce); end
            checks++;
            if (halted !== ex.halted) begin errors++; $display("FAIL bounce_halted k=%0d: got %b want %b", k, halted, ex.halted); end
        end
    endtask

    // Press reaches step_req after 2 sync + 3 debounce edges, STEP one edge later,
    // then CE on the edge after the next divider tick.
    task automatic test_step(input bit with_halt_req);
        int unsigned e0, ece;
        int          seen;
        @(posedge clk); #1;
        btn  = 1'b1;
        e0   = e;
        ece  = ((e0 + 7 + 3) / 4) * 4;
        seen = 0;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            exp_q.push_back('{ce: (e == ece), halted: !((e >= e0 + 6) && (e < ece))});
            @(negedge clk);
            ex = exp_q.pop_front();
            if (cpu_ce === 1'b1) seen++;
            checks++;
            if (cpu_ce !== ex.ce) begin errors++; $display("FAIL step_ce hr=%0b k=%0d: got %b want %b", with_halt_req, k, cpu_ce, ex.ce); end
            checks++;
            if (halted !== ex.halted) begin errors++; $display("FAIL step_halted hr=%0b k=%0d: got %b want %b", with_halt_req, k, halted, ex.halted); end
        end
        checks++;
        if (seen != 1) begin errors++; $display("FAIL step_count hr=%0b: got %0d want 1", with_halt_req, seen); end
        @(posedge clk); #1;
        btn = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            exp_q.push_back('{ce: 1'b0, halted: 1'b1});
            @(negedge clk);
            ex = exp_q.pop_front();
            checks++;
            if (cpu_ce !== ex.ce) begin errors++; $display("FAIL release_ce k=%0d: got %b want %b", k, cpu_ce, ex.ce); end
            checks++;
            if (halted !== ex.halted) begin errors++; $display("FAIL release_halted k=%0d: got %b want %b", k, halted, ex.halted); end
        end
    endtask

    task automatic test_step_past_halt();
        @(posedge clk); #1;
        halt_req = 1'b1;
        sw_run   = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            exp_q.push_back('{ce: 1'b0, halted: 1'b1});
            @(negedge clk);
            ex = exp_q.pop_front();
            checks++;
            if (cpu_ce !== ex.ce) begin errors++; $display("FAIL hr_hold_ce k=%0d: got %b want %b", k, cpu_ce, ex.ce); end
            checks++;
            if (halted !== ex.halted) begin errors++; $display("FAIL hr_hold_halted k=%0d: got %b want %b", k, halted, ex.halted); end
        end
        test_step(1'b1);
        @(posedge clk); #1;
        halt_req = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            exp_q.push_back('{ce: (k >= 2) && (e % 4 == 0), halted: 1'b0});
            @(negedge clk);
            ex = exp_q.pop_front();
            checks++;
            if (cpu_ce !== ex.ce) begin errors++; $display("FAIL resume_ce k=%0d: got %b want %b", k, cpu_ce, ex.ce); end
            checks++;
            if (halted !== ex.halted) begin errors++; $display("FAIL resume_halted k=%0d: got %b want %b", k, halted, ex.halted); end
        end
    endtask

    task automatic test_async_reset();
        int k;
        k = 0;
        @(negedge clk);
        while (cpu_ce !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (cpu_ce !== 1'b1) begin errors++; $display("FAIL arst_pre_ce: got %b want 1", cpu_ce); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cpu_ce !== 1'b0) begin errors++; $display("FAIL arst_ce: got %b want 0", cpu_ce); end
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL arst_halted: got %b want 1", halted); end
`ifdef OTTER_CLK_CE_COUNT_EN
        checks++;
        if (ce_count !== 32'd0) begin errors++; $display("FAIL arst_count: got %0d want 0", ce_count); end
`endif
        sw_run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

`ifdef OTTER_CLK_CE_COUNT_EN
    task automatic test_ce_count();
        int seen;
        @(posedge clk); #1;
        rst_n    = 1'b0;
        sw_run   = 1'b1;
        halt_req = 1'b0;
        btn      = 1'b0;
        @(negedge clk);
        checks++;
        if (ce_count !== 32'd0) begin errors++; $display("FAIL count_reset: got %0d want 0", ce_count); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen  = 0;
        for (int k = 0; k < 80 && seen < 10; k++) begin
            @(negedge clk);
            if (cpu_ce === 1'b1) seen++;
        end
        checks++;
        if (seen != 10) begin errors++; $display("FAIL count_ces: got %0d want 10", seen); end
        @(negedge clk);
        checks++;
        if (ce_count !== 32'd10) begin errors++; $display("FAIL count_value: got %0d want 10", ce_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_run();
        test_halt_req();
        test_sw_halt();
        test_bounce();
        test_step(1'b0);
        test_step_past_halt();
        test_async_reset();
`ifdef OTTER_CLK_CE_COUNT_EN
        test_ce_count();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
